// File: rtl/burst_seq_pkg.sv
// Shared types, default widths and the config-bus slot helper for the burst sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package burst_seq_pkg;

    localparam int DEF_DIV_W   = 12;
    localparam int DEF_PULSE_W = 4;
    localparam int DEF_GAP_W   = 10;
    localparam int DEF_REP_W   = 8;

    // Packed config buses are zero-extended to this width before slicing.
    localparam int CFG_BUS_W = 256;
    localparam int SLOT_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_GAP,
        ST_DONE
    } state_t;

    function automatic logic [SLOT_W-1:0] cfg_slot(input logic [CFG_BUS_W-1:0] bus,
                                                   input int unsigned idx,
                                                   input int unsigned w);
        logic [CFG_BUS_W-1:0] sh;
        sh = bus >> (idx * w);
        return sh[SLOT_W-1:0] & ((SLOT_W'(1) << w) - SLOT_W'(1));
    endfunction

endpackage

// File: rtl/burst_phase_timer.sv
// Loadable down-counter timing the HIGH/LOW/GAP intervals; cnt_zero flags expiry.
// Latency: loaded value visible the cycle after ld; counts down one per cycle, holds at 0.
// Backpressure: none; ld always wins over counting.
module burst_phase_timer #(
    parameter int W = 12
) (
    input  logic         core_clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic         cnt_zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = ld_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/multi_phase_burst_sequencer.sv
// Multi-phase burst clock generator; BURST_RUNOUT_EN adds a one-cycle flush pulse when en drops mid-burst.
// Latency: SAMPLE_CLK rises the cycle after en is sampled high; all outputs are registered or decoded from state.
// Backpressure: none; en low returns to IDLE on the next edge, overriding every other transition.
module multi_phase_burst_sequencer
    import burst_seq_pkg::*;
#(
    parameter  int NUM_PHASES = 4,
    parameter  int DIV_W      = DEF_DIV_W,
    parameter  int PULSE_W    = DEF_PULSE_W,
    parameter  int GAP_W      = DEF_GAP_W,
    parameter  int REP_W      = DEF_REP_W,
    localparam int IDX_W      = $clog2(NUM_PHASES)
) (
    input  logic                        HF_CLK,
    input  logic                        RST_sync,
    input  logic                        ENSAMP_sync,
    input  logic                        TEMP_RUN,
    input  logic [NUM_PHASES*DIV_W-1:0]   DIV_sync,
    input  logic [NUM_PHASES*PULSE_W-1:0] PCOUNT_sync,
    input  logic [NUM_PHASES*GAP_W-1:0]   GAP_sync,
    input  logic [IDX_W-1:0]            NPHASE_sync,
    input  logic [REP_W-1:0]            NBURST_sync,
    output logic                        SAMPLE_CLK,
    output logic [IDX_W-1:0]            PHASE_IDX,
    output logic                        IN_GAP,
    output logic                        BUSY,
    output logic                        SEQ_DONE
);

    localparam int TW = (DIV_W > GAP_W) ? DIV_W : GAP_W;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, last_idx, nxt_idx, ent_idx;
    logic [PULSE_W-1:0] pulse_q, pulse_d, ent_pc;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic               cont_q, cont_d;
    logic [DIV_W-1:0]   div_q, div_d, ent_div_raw, ent_div;
    logic [GAP_W-1:0]   gap_q, gap_d, ent_gap;
    logic               sample_q, sample_d;
    logic               seq_done_q, seq_done_d;
    logic               en, busy_q, wrap, adv, enter;
    logic               tmr_ld, tmr_zero;
    logic [TW-1:0]      tmr_val;
    logic [CFG_BUS_W-1:0] div_bus, pc_bus, gap_bus;

    assign en     = ENSAMP_sync | TEMP_RUN;
    assign busy_q = (state_q == ST_HIGH) || (state_q == ST_LOW) || (state_q == ST_GAP);

    assign last_idx = (32'(NPHASE_sync) >= NUM_PHASES) ? IDX_W'(NUM_PHASES - 1) : NPHASE_sync;
    assign wrap     = (idx_q >= last_idx);
    assign nxt_idx  = wrap ? '0 : idx_q + IDX_W'(1);
    assign ent_idx  = (state_q == ST_IDLE) ? '0 : nxt_idx;

    // Config of the phase about to be entered; latched into div_q/gap_q/pulse_q on entry.
    assign div_bus     = {{(CFG_BUS_W - NUM_PHASES*DIV_W){1'b0}}, DIV_sync};
    assign pc_bus      = {{(CFG_BUS_W - NUM_PHASES*PULSE_W){1'b0}}, PCOUNT_sync};
    assign gap_bus     = {{(CFG_BUS_W - NUM_PHASES*GAP_W){1'b0}}, GAP_sync};
    assign ent_div_raw = DIV_W'(cfg_slot(div_bus, 32'(ent_idx), DIV_W));
    assign ent_pc      = PULSE_W'(cfg_slot(pc_bus, 32'(ent_idx), PULSE_W));
    assign ent_gap     = GAP_W'(cfg_slot(gap_bus, 32'(ent_idx), GAP_W));
    assign ent_div     = (ent_div_raw == '0) ? DIV_W'(1) : ent_div_raw;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pulse_d    = pulse_q;
        rep_d      = rep_q;
        cont_d     = cont_q;
        div_d      = div_q;
        gap_d      = gap_q;
        seq_done_d = 1'b0;
        tmr_ld     = 1'b0;
        tmr_val    = '0;
        adv        = 1'b0;
        enter      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    cont_d = (NBURST_sync == '0);
                    rep_d  = (NBURST_sync == '0) ? '0 : NBURST_sync - REP_W'(1);
                    enter  = 1'b1;
                end
            end
            ST_HIGH: begin
                if (tmr_zero) begin
                    state_d = ST_LOW;
                    tmr_ld  = 1'b1;
                    tmr_val = TW'(div_q - DIV_W'(1));
                end
            end
            ST_LOW: begin
                if (tmr_zero) begin
                    if (pulse_q != '0) begin
                        state_d = ST_HIGH;
                        pulse_d = pulse_q - PULSE_W'(1);
                        tmr_ld  = 1'b1;
                        tmr_val = TW'(div_q - DIV_W'(1));
                    end else if (gap_q != '0) begin
                        state_d = ST_GAP;
                        tmr_ld  = 1'b1;
                        tmr_val = TW'(gap_q - GAP_W'(1));
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    adv = 1'b1;
                end
            end
            ST_DONE: begin
            end
            default: state_d = ST_IDLE;
        endcase

        if (adv) begin
            if (wrap && !cont_q && (rep_q == '0)) begin
                state_d    = ST_DONE;
                idx_d      = '0;
                seq_done_d = 1'b1;
                tmr_ld     = 1'b1;
            end else begin
                enter = 1'b1;
                if (wrap && !cont_q) begin
                    rep_d = rep_q - REP_W'(1);
                end
            end
        end

        // An empty phase (no pulses, no gap) spends a single LOW cycle so the FSM never stalls.
        if (enter) begin
            idx_d  = ent_idx;
            div_d  = ent_div;
            gap_d  = ent_gap;
            tmr_ld = 1'b1;
            if (ent_pc != '0) begin
                state_d = ST_HIGH;
                pulse_d = ent_pc - PULSE_W'(1);
                tmr_val = TW'(ent_div - DIV_W'(1));
            end else if (ent_gap != '0) begin
                state_d = ST_GAP;
                pulse_d = '0;
                tmr_val = TW'(ent_gap - GAP_W'(1));
            end else begin
                state_d = ST_LOW;
                pulse_d = '0;
                tmr_val = '0;
            end
        end

        if (!en) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            pulse_d    = '0;
            rep_d      = '0;
            cont_d     = 1'b0;
            div_d      = '0;
            gap_d      = '0;
            seq_done_d = 1'b0;
            tmr_ld     = 1'b1;
            tmr_val    = '0;
        end

`ifdef BURST_RUNOUT_EN
        sample_d = (state_d == ST_HIGH) || (!en && busy_q);
`else
        sample_d = (state_d == ST_HIGH);
`endif
    end

    burst_phase_timer #(
        .W(TW)
    ) u_timer (
        .core_clk (HF_CLK),
        .rst      (RST_sync),
        .ld       (tmr_ld),
        .ld_val   (tmr_val),
        .cnt_zero (tmr_zero)
    );

    always_ff @(posedge HF_CLK) begin
        if (RST_sync) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            pulse_q    <= '0;
            rep_q      <= '0;
            cont_q     <= 1'b0;
            div_q      <= '0;
            gap_q      <= '0;
            sample_q   <= 1'b0;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pulse_q    <= pulse_d;
            rep_q      <= rep_d;
            cont_q     <= cont_d;
            div_q      <= div_d;
            gap_q      <= gap_d;
            sample_q   <= sample_d;
            seq_done_q <= seq_done_d;
        end
    end

    assign SAMPLE_CLK = sample_q;
    assign PHASE_IDX  = idx_q;
    assign IN_GAP     = (state_q == ST_GAP);
    assign BUSY       = busy_q;
    assign SEQ_DONE   = seq_done_q;

endmodule

// File: tb/tb_multi_phase_burst_sequencer.sv
// Directed bench for multi_phase_burst_sequencer: per-cycle waveform strings against hand-derived sequences.
// Wave letters: H=pulse high, L=pulse low, G=gap, D=seq-done cycle, R=runout pulse (not busy), '-'=all low.
module tb_multi_phase_burst_sequencer;

    localparam int NP = 4;
    localparam int DW = 12;
    localparam int PW = 4;
    localparam int GW = 10;
    localparam int RW = 8;
    localparam int IW = 2;

    logic            hf_clk = 1'b0;
    logic            rst;
    logic            ensamp;
    logic            temp_run;
    logic [NP*DW-1:0] div_cfg;
    logic [NP*PW-1:0] pc_cfg;
    logic [NP*GW-1:0] gap_cfg;
    logic [IW-1:0]   nphase;
    logic [RW-1:0]   nburst;
    logic            sample_clk;
    logic [IW-1:0]   phase_idx;
    logic            in_gap;
    logic            busy;
    logic            seq_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 hf_clk = ~hf_clk;

    multi_phase_burst_sequencer dut (
        .HF_CLK      (hf_clk),
        .RST_sync    (rst),
        .ENSAMP_sync (ensamp),
        .TEMP_RUN    (temp_run),
        .DIV_sync    (div_cfg),
        .PCOUNT_sync (pc_cfg),
        .GAP_sync    (gap_cfg),
        .NPHASE_sync (nphase),
        .NBURST_sync (nburst),
        .SAMPLE_CLK  (sample_clk),
        .PHASE_IDX   (phase_idx),
        .IN_GAP      (in_gap),
        .BUSY        (busy),
        .SEQ_DONE    (seq_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // {SAMPLE_CLK, IN_GAP, BUSY, SEQ_DONE, PHASE_IDX}
    function automatic logic [31:0] obs();
        return {26'd0, sample_clk, in_gap, busy, seq_done, phase_idx};
    endfunction

    function automatic logic [31:0] code(input byte w, input byte p);
        logic [3:0] f;
        case (w)
            "H":     f = 4'b1010;
            "L":     f = 4'b0010;
            "G":     f = 4'b0110;
            "D":     f = 4'b0001;
            "R":     f = 4'b1000;
            default: f = 4'b0000;
        endcase
        return {26'd0, f, 2'(p - 8'h30)};
    endfunction

    task automatic run_pattern(input string tag, input string wav, input string ph);
        for (int i = 0; i < wav.len(); i++) begin
            @(negedge hf_clk);
            chk($sformatf("%s[%0d]", tag, i), obs(), code(wav[i], ph[i]));
        end
    endtask

    task automatic set_phase(input int p, input int d, input int pc, input int g);
        div_cfg[p*DW +: DW] = DW'(d);
        pc_cfg[p*PW +: PW]  = PW'(pc);
        gap_cfg[p*GW +: GW] = GW'(g);
    endtask

    initial begin
        string seq;
        string seqp;
        string runout_wav;

`ifdef BURST_RUNOUT_EN
        runout_wav = "R-";
`else
        runout_wav = "--";
`endif
        seq  = "HHLLHHLLGGGGHHHLLL";
        seqp = "000000000000111111";

        rst      = 1'b1;
        ensamp   = 1'b0;
        temp_run = 1'b0;
        div_cfg  = '0;
        pc_cfg   = '0;
        gap_cfg  = '0;
        nphase   = '0;
        nburst   = '0;
        repeat (3) @(negedge hf_clk);
        chk("reset_outputs", obs(), 32'd0);
        rst = 1'b0;
        run_pattern("idle_en_low", "--", "00");

        // Two phases, one repetition, then DONE holds with en still high.
        set_phase(0, 2, 2, 4);
        set_phase(1, 3, 1, 0);
        nphase = 2'd1;
        nburst = 8'd1;
        ensamp = 1'b1;
        run_pattern("seq1", "HHLLHHLLGGGGHHHLLLD---", "0000000000001111110000");
        ensamp = 1'b0;
        run_pattern("seq1_off", "-", "0");

        // Continuous via TEMP_RUN, then drop en during phase 1 HIGH.
        nburst   = 8'd0;
        temp_run = 1'b1;
        run_pattern("cont", {seq, seq, seq, "HHLLHHLLGGGGHH"}, {seqp, seqp, seqp, "00000000000011"});
        temp_run = 1'b0;
        run_pattern("en_drop", runout_wav, "00");

        // Phase 0 gap-only, phase 1 with DIV=0 treated as 1.
        set_phase(0, 7, 0, 5);
        set_phase(1, 0, 3, 0);
        nburst = 8'd1;
        ensamp = 1'b1;
        run_pattern("gap_div0", "GGGGGHLHLHLD-", "0000011111100");
        ensamp = 1'b0;
        run_pattern("gap_div0_off", "-", "0");

        // Index 7 seen through the 2-bit port selects the last slot; two repetitions.
        for (int p = 0; p < NP; p++) set_phase(p, 1, 1, 0);
        nphase = IW'(7);
        nburst = 8'd2;
        ensamp = 1'b1;
        run_pattern("four_ph", "HLHLHLHLHLHLHLHLD-", "001122330011223300");
        ensamp = 1'b0;
        run_pattern("four_ph_off", "-", "0");

        // All phases empty: one cycle each, no pulses, no lockup.
        for (int p = 0; p < NP; p++) set_phase(p, 0, 0, 0);
        nburst = 8'd1;
        ensamp = 1'b1;
        run_pattern("empty", "LLLLD-", "012300");
        ensamp = 1'b0;
        run_pattern("empty_off", "-", "0");

        // Reset in the middle of phase 0 gap with en held high.
        set_phase(0, 2, 2, 4);
        set_phase(1, 3, 1, 0);
        set_phase(2, 0, 0, 0);
        set_phase(3, 0, 0, 0);
        nphase = 2'd1;
        ensamp = 1'b1;
        run_pattern("pre_rst", "HHLLHHLLGG", "0000000000");
        rst = 1'b1;
        run_pattern("mid_gap_rst", "-", "0");
        rst = 1'b0;
        run_pattern("post_rst", "HHLLH", "00000");
        ensamp = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
